// File: rtl/l2cache_nway_control.sv
// N-way write-back/write-allocate L2 control FSM; hit answers 1 cycle after request, a miss costs its pmem bursts + COMMIT + IDLE + SERVE.
// Backpressure: mem_* is held until the mem_resp pulse; the pmem burst stalls on pmem_resp=0 with state and beat_cnt frozen.
module l2cache_nway_control #(
    parameter int NUM_WAYS    = 4,
    parameter int WAY_BITS    = $clog2(NUM_WAYS),
    parameter int BURST_BEATS = 4,
    parameter int BEAT_BITS   = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic [NUM_WAYS-1:0]  cache_hit,
    input  logic [WAY_BITS-1:0]  way,
    input  logic                 dirty_victim,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [BEAT_BITS-1:0] beat_cnt,
    output logic                 load_line_beat,
    output logic [WAY_BITS-1:0]  way_sel,
    output logic                 load_way_reg,
    output logic [NUM_WAYS-1:0]  load_tag,
    output logic [NUM_WAYS-1:0]  load_valid,
    output logic                 set_valid,
    output logic [NUM_WAYS-1:0]  load_dirty,
    output logic                 set_dirty,
    output logic                 load_lru,
    output logic [NUM_WAYS-1:0]  read_data_array,
    output logic [1:0]           write_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_COMMIT,
        S_SERVE
    } state_t;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_BEATS - 1);

    state_t              state;
    logic [WAY_BITS-1:0] way_reg;
    logic                refill;

    logic                req;
    logic                hit;
    logic                last_beat;
    logic [NUM_WAYS-1:0] way_oh;
    logic [NUM_WAYS-1:0] way_reg_oh;

    assign req        = mem_read | mem_write;
    assign hit        = |cache_hit;
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign way_oh     = NUM_WAYS'(1) << way;
    assign way_reg_oh = NUM_WAYS'(1) << way_reg;

    always_comb begin
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        load_line_beat  = 1'b0;
        way_sel         = way_reg;
        load_way_reg    = 1'b0;
        load_tag        = '0;
        load_valid      = '0;
        set_valid       = 1'b0;
        load_dirty      = '0;
        set_dirty       = 1'b0;
        load_lru        = 1'b0;
        read_data_array = '0;
        write_sel       = 2'b00;

        case (state)
            S_IDLE: begin
                if (req) begin
                    load_way_reg = 1'b1;
                    way_sel      = way;
                    if (hit) begin
                        load_lru = 1'b1;
                        // A simultaneous read+write is treated as a write.
                        if (mem_write) begin
                            load_dirty = way_oh;
                            set_dirty  = 1'b1;
                            write_sel  = 2'b10;
                        end else begin
                            read_data_array = way_oh;
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write      = 1'b1;
                read_data_array = way_reg_oh;
                if (pmem_resp && last_beat) begin
                    load_dirty = way_reg_oh;
                end
            end
            S_ALLOCATE: begin
                pmem_read      = 1'b1;
                load_line_beat = pmem_resp;
            end
            S_COMMIT: begin
                write_sel  = 2'b01;
                load_tag   = way_reg_oh;
                load_valid = way_reg_oh;
                set_valid  = 1'b1;
                load_dirty = way_reg_oh;
            end
            S_SERVE: begin
                mem_resp = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            way_reg    <= '0;
            beat_cnt   <= '0;
            refill     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        way_reg <= way;
                        if (hit) begin
                            state  <= S_SERVE;
                            refill <= 1'b0;
                            // The post-refill replay was already counted as a miss.
                            if (!refill && (hit_count != '1)) begin
                                hit_count <= hit_count + 1'b1;
                            end
                        end else begin
                            state    <= dirty_victim ? S_WRITEBACK : S_ALLOCATE;
                            beat_cnt <= '0;
                            if (miss_count != '1) begin
                                miss_count <= miss_count + 1'b1;
                            end
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= S_ALLOCATE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= S_COMMIT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    refill <= 1'b1;
                    state  <= S_IDLE;
                end
                S_SERVE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/l2cache_nway_control.md
Name: l2cache_nway_control

Overview:
- Parametrised control FSM for a set-associative, write-back, write-allocate L2 cache, with a way count of NUM_WAYS.
- Sits between the L1-side request port (mem_*) and a burst physical-memory port (pmem_*), and drives the tag/valid/dirty/LRU/data-array load strobes of the L2 datapath.
- New over the fixed 4-way controller:
  - parametrised way count;
  - multi-beat pmem bursts with a beat counter;
  - a separate fill-commit state;
  - saturating hit/miss performance counters that count each request exactly once.

Parameters:
NUM_WAYS, 4, number of ways (power of 2, >=2)
WAY_BITS, $clog2(NUM_WAYS), way index width
BURST_BEATS, 4, pmem beats per cache line (power of 2, >=1)
BEAT_BITS, $clog2(BURST_BEATS) (min 1), beat counter width
CNT_WIDTH, 32, performance counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_read  in  1  L1 read request, held until mem_resp
mem_write  in  1  L1 write request, held until mem_resp
mem_resp  out  1  one-cycle request completion
cache_hit  in  NUM_WAYS  one-hot hit vector from tag compare
way  in  WAY_BITS  hit way index if hit, else LRU victim index
dirty_victim  in  1  victim line is valid and dirty
pmem_resp  in  1  one pmem beat accepted/returned this cycle
pmem_read  out  1  burst read in progress
pmem_write  out  1  burst write in progress
beat_cnt  out  BEAT_BITS  current beat index within the burst
load_line_beat  out  1  datapath captures the pmem read beat at beat_cnt into the line buffer
way_sel  out  WAY_BITS  way driving the datapath muxes
load_way_reg  out  1  datapath latches way
load_tag  out  NUM_WAYS  per-way tag load
load_valid  out  NUM_WAYS  per-way valid load
set_valid  out  1  value for valid load
load_dirty  out  NUM_WAYS  per-way dirty load
set_dirty  out  1  value for dirty load
load_lru  out  1  update LRU for way_sel
read_data_array  out  NUM_WAYS  per-way data read enable
write_sel  out  2  data write source: 00 none, 01 line buffer, 10 L1 write data
hit_count  out  CNT_WIDTH  saturating hit count
miss_count  out  CNT_WIDTH  saturating miss count

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE, COMMIT, SERVE. Outputs are combinational from state and inputs.
- Registers:
  - state;
  - way_reg (WAY_BITS);
  - beat_cnt;
  - refill flag;
  - hit_count and miss_count.
- Defaults: every strobe is 0, write_sel=00, way_sel=way_reg.
- Reset (rst=1 at an edge, from any state including mid-burst): state=IDLE, way_reg=0, beat_cnt=0, refill=0, both counters=0. pmem_read and pmem_write are 0 from the first cycle after reset.
- IDLE with no request: defaults only, next state IDLE.
- IDLE with a request (mem_read or mem_write):
  - load_way_reg=1, way_reg<=way, way_sel=way.
  - Hit (cache_hit!=0):
    - load_lru=1; next state SERVE.
    - Write: load_dirty[way]=1, set_dirty=1, write_sel=10.
    - Read only: read_data_array[way]=1.
    - mem_read and mem_write both asserted is handled as a write.
    - If refill=0, hit_count increments. refill clears.
  - Miss with dirty_victim=1: next state WRITEBACK, beat_cnt<=0, miss_count increments.
  - Miss with dirty_victim=0: next state ALLOCATE, beat_cnt<=0, miss_count increments.
- WRITEBACK:
  - pmem_write=1 and read_data_array[way_reg]=1 throughout.
  - Each pmem_resp increments beat_cnt.
  - On pmem_resp with beat_cnt==BURST_BEATS-1:
    - load_dirty[way_reg]=1, set_dirty=0;
    - beat_cnt wraps to 0;
    - next state ALLOCATE.
- ALLOCATE:
  - pmem_read=1 throughout.
  - On each pmem_resp: load_line_beat=1, beat_cnt increments.
  - On the last beat: beat_cnt wraps to 0, next state COMMIT.
- COMMIT (exactly one cycle):
  - write_sel=01;
  - load_tag[way_reg]=1;
  - load_valid[way_reg]=1, set_valid=1;
  - load_dirty[way_reg]=1, set_dirty=0;
  - refill<=1; next state IDLE.
  - The request is then re-evaluated in IDLE as a hit.
- SERVE: mem_resp=1 for one cycle, next state IDLE.
- Latency:
  - hit: mem_resp 1 cycle after the request cycle;
  - clean miss: BURST_BEATS pmem beats + COMMIT + IDLE + SERVE;
  - dirty miss: adds BURST_BEATS write beats.
- pmem_resp in IDLE, COMMIT or SERVE is ignored. pmem_resp=0 holds the current state and beat_cnt.
- Counters saturate at all-ones and never wrap.
- One-hot strobes: at most one bit of load_tag, load_valid, load_dirty and read_data_array is set in any cycle.

Test Plan:
- Read hit, NUM_WAYS=4, cache_hit=0100, way=2 -> read_data_array=0100 and load_lru=1 in the request cycle; mem_resp the next cycle; hit_count=1.
- Write hit, way=1 -> load_dirty=0010, set_dirty=1, write_sel=10; mem_resp after 1 cycle; no pmem activity.
- Clean read miss, BURST_BEATS=4, way=3, pmem_resp on alternate cycles:
  - pmem_read held for 8 cycles; 4 load_line_beat pulses with beat_cnt 0..3;
  - COMMIT asserts load_tag=1000, load_valid=1000, write_sel=01;
  - mem_resp follows; miss_count=1, hit_count=0.
- Dirty miss, way=0 -> 4 pmem_write beats with read_data_array=0001, dirty cleared on beat 3, then 4 read beats, then COMMIT; exactly one miss counted.
- rst asserted during ALLOCATE at beat_cnt=2 -> next cycle: state IDLE, pmem_read=0, beat_cnt=0, counters=0.
- CNT_WIDTH=4 with 17 hits -> hit_count holds at 15.
